// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: one access per three cycles,
// round-robin or fixed priority, with optional word-alignment checking.
module dmem_arbiter #(
  parameter int unsigned FIXED_PRI = 0,
  parameter int unsigned ALIGN_CHK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] ReadData
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        win;
  logic        mis;

  assign mis = (ALIGN_CHK != 0) && (addr_q[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    win     = 1'b0;
    case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // On a tie, round-robin hands the grant to the port not served last.
          if (req0 && req1) win = (FIXED_PRI != 0) ? 1'b0 : ~last_q;
          else              win = req1;
          state_d = StAccess;
          gnt_d   = win;
          last_d  = win;
          we_d    = win ? we1 : we0;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
        end
      end
      StAccess: begin
        state_d = StResp;
        if (!we_q && !mis) rdata_d = ReadData;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    Address   = '0;
    WriteData = '0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    if (state_q == StAccess) begin
      Address   = addr_q;
      WriteData = wdata_q;
      MemWrite  = we_q && !mis;
      MemRead   = !we_q && !mis;
    end
  end

  assign ack0  = (state_q == StResp) && !gnt_q;
  assign ack1  = (state_q == StResp) && gnt_q;
  assign err0  = ack0 && mis;
  assign err1  = ack1 && mis;
  assign busy  = (state_q != StIdle);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: round-robin instance with a small memory model, plus a fixed-priority
// instance sharing the same request stimulus.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1, busy, MemWrite, MemRead;
  logic [31:0] rdata, Address, WriteData, ReadData;
  logic        fx_ack0, fx_ack1, fx_err0, fx_err1, fx_busy, fx_MemWrite, fx_MemRead;
  logic [31:0] fx_rdata, fx_Address, fx_WriteData;
  logic        mem_clr;
  logic [31:0] mem [16];
  int          nchk = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.FIXED_PRI(0), .ALIGN_CHK(1)) u_dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata), .busy(busy),
    .Address(Address), .WriteData(WriteData), .MemWrite(MemWrite), .MemRead(MemRead),
    .ReadData(ReadData)
  );

  dmem_arbiter #(.FIXED_PRI(1), .ALIGN_CHK(1)) u_fix (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(fx_ack0), .ack1(fx_ack1), .err0(fx_err0), .err1(fx_err1), .rdata(fx_rdata),
    .busy(fx_busy), .Address(fx_Address), .WriteData(fx_WriteData),
    .MemWrite(fx_MemWrite), .MemRead(fx_MemRead), .ReadData(32'h0)
  );

  assign ReadData = mem[Address[5:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (MemWrite) begin
      mem[Address[5:2]] <= WriteData;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; mem_clr = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    tick(); tick();
    reset = 1'b0; mem_clr = 1'b0;

    // Reset state of both instances
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_acks", {28'h0, ack0, ack1, err0, err1}, 32'h0);
    chk("rst_strb", {30'h0, MemWrite, MemRead}, 32'h0);
    chk("rst_addr", Address, 32'h0);
    chk("rst_wdat", WriteData, 32'h0);
    chk("rst_rdat", rdata, 32'h0);
    chk("fx_rst_ctl", {25'h0, fx_busy, fx_ack0, fx_ack1, fx_err0, fx_err1, fx_MemWrite,
                       fx_MemRead}, 32'h0);
    chk("fx_rst_dat", fx_rdata | fx_Address | fx_WriteData, 32'h0);

    // Port 0 write 0x4 then read back
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h4; wdata0 = 32'hA5A5A5A5;
    tick();
    req0 = 1'b0;
    chk("w0_acc_strb", {30'h0, MemWrite, MemRead}, 32'h2);
    chk("w0_acc_addr", Address, 32'h4);
    chk("w0_acc_wdat", WriteData, 32'hA5A5A5A5);
    chk("w0_acc_busy", {31'h0, busy}, 32'h1);
    chk("w0_acc_ack", {30'h0, ack0, ack1}, 32'h0);
    tick();
    chk("w0_resp_ack", {28'h0, ack0, ack1, err0, err1}, 32'h8);
    chk("w0_resp_strb", {30'h0, MemWrite, MemRead}, 32'h0);
    chk("w0_resp_addr", Address, 32'h0);
    tick();
    chk("w0_idle", {29'h0, busy, ack0, ack1}, 32'h0);
    chk("w0_mem", mem[1], 32'hA5A5A5A5);

    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h4;
    tick();
    req0 = 1'b0;
    chk("r0_acc_strb", {30'h0, MemWrite, MemRead}, 32'h1);
    chk("r0_acc_rdat", rdata, 32'h0);
    tick();
    chk("r0_resp_ack", {28'h0, ack0, ack1, err0, err1}, 32'h8);
    chk("r0_rdata", rdata, 32'hA5A5A5A5);
    tick();

    // Misaligned port 1 write to 0x6
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h6; wdata1 = 32'hFFFF_FFFF;
    tick();
    req1 = 1'b0;
    chk("mis_acc_strb", {30'h0, MemWrite, MemRead}, 32'h0);
    chk("mis_acc_busy", {31'h0, busy}, 32'h1);
    tick();
    chk("mis_resp", {28'h0, ack0, ack1, err0, err1}, 32'h5);
    tick();
    chk("mis_idle_err", {28'h0, ack0, ack1, err0, err1}, 32'h0);
    chk("mis_mem", mem[1], 32'hA5A5A5A5);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h4;
    tick();
    req0 = 1'b0;
    tick();
    chk("mis_rb_ack", {30'h0, ack0, ack1}, 32'h2);
    chk("mis_rb_rdata", rdata, 32'hA5A5A5A5);
    tick();

    // Reset in the ACCESS cycle of a write aborts it
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'hC; wdata0 = 32'hDEAD_BEEF;
    tick();
    chk("abt_acc", {30'h0, MemWrite, busy}, 32'h3);
    reset = 1'b1; req0 = 1'b0;
    tick();
    reset = 1'b0;
    chk("abt_ctl", {26'h0, busy, ack0, ack1, err0, MemWrite, MemRead}, 32'h0);
    chk("abt_bus", Address | WriteData, 32'h0);
    tick();
    chk("abt_noack", {29'h0, busy, ack0, ack1}, 32'h0);
    chk("abt_fx", {29'h0, fx_busy, fx_ack0, fx_ack1}, 32'h0);

    // Tie with both ports holding req: round-robin 0,1,0,1; fixed priority port 0 only
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h12345678;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h8;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("tie_acc_addr", Address, 32'h8);
      chk("tie_acc_strb", {30'h0, MemWrite, MemRead}, (k % 2 == 0) ? 32'h2 : 32'h1);
      chk("fx_tie_acc", {30'h0, fx_MemWrite, fx_MemRead}, 32'h2);
      tick();
      chk("tie_ack", {30'h0, ack0, ack1}, (k % 2 == 0) ? 32'h2 : 32'h1);
      chk("fx_tie_ack", {28'h0, fx_ack0, fx_ack1, fx_err0, fx_err1}, 32'h8);
      if (k % 2 == 1) chk("tie_rdata", rdata, 32'h12345678);
      tick();
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      chk("tie_idle", {29'h0, busy, ack0, ack1}, 32'h0);
    end

    // req1 raised during port 0's ACCESS waits for IDLE; ack1 three cycles after ack0
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h8;
    tick();
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4;
    chk("late_acc0", Address, 32'h8);
    tick();
    chk("late_ack0", {30'h0, ack0, ack1}, 32'h2);
    tick();
    chk("late_idle", {29'h0, busy, ack0, ack1}, 32'h0);
    tick();
    req1 = 1'b0;
    chk("late_acc1", Address, 32'h4);
    chk("late_acc1_ack", {30'h0, ack0, ack1}, 32'h0);
    tick();
    chk("late_ack1", {28'h0, ack0, ack1, err0, err1}, 32'h4);
    chk("late_rdata", rdata, 32'hA5A5A5A5);
    tick();
    chk("late_end", {29'h0, busy, ack0, ack1}, 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
